// File: rtl/word_loader.sv
// rtl/word_loader.sv - length-prefixed word stream loader into on-chip memory
// Header word gives the word count; data words are written from BASE_ADDR upward without wrapping.
module word_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              load,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

    // Address arithmetic is carried two bits wider than either operand so nothing truncates.
    localparam int                EXT_W    = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 2;
    localparam logic [EXT_W-1:0]  LIMIT    = EXT_W'(1) << ADDR_W;
    localparam logic [EXT_W-1:0]  BASE_EXT = EXT_W'(BASE_ADDR);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   len_q, len_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;

    logic                accept;
    logic                last_word;
    logic [EXT_W-1:0]    wr_addr_ext;
    logic [EXT_W-1:0]    xfer_end;

    assign in_ready     = (state_q == S_HDR) || (state_q == S_DATA);
    assign load         = in_ready;
    assign busy         = in_ready;
    assign done         = (state_q == S_DONE);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign err_overflow = err_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        accept      = in_valid && in_ready;
        wr_addr_ext = BASE_EXT + EXT_W'(idx_q);
        xfer_end    = BASE_EXT + EXT_W'(in_data);
        last_word   = (EXT_W'(idx_q) + EXT_W'(1)) == EXT_W'(len_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    err_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    len_d = in_data;
                    if (xfer_end > LIMIT) begin
                        err_d = 1'b1;
                    end
                    state_d = (in_data == '0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Words past the top of memory are consumed but not written.
                    addr_d  = wr_addr_ext[ADDR_W-1:0];
                    wdata_d = in_data;
                    we_d    = (wr_addr_ext < LIMIT);
                    idx_d   = idx_q + DATA_W'(1);
                    if (last_word) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_word_loader.sv
// tb/tb_word_loader.sv - directed bench for word_loader
// A second instance with a 4-word memory at base 2 shares the stimulus to exercise overflow.
module tb_word_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;

    logic        load, in_ready, mem_we, busy, done, err_overflow;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;

    logic        load2, in_ready2, mem_we2, busy2, done2, err_overflow2;
    logic [1:0]  mem_addr2;
    logic [15:0] mem_wdata2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int wr_cyc[$], wr_addr[$], wr_data[$], acc_cyc[$], done_cyc[$];
    int w2_addr[$], w2_data[$];

    always #5 clk = ~clk;

    word_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load(load),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err_overflow(err_overflow)
    );

    word_loader #(.DATA_W(16), .ADDR_W(2), .BASE_ADDR(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .load(load2),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .busy(busy2), .done(done2), .err_overflow(err_overflow2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(int'(mem_wdata));
        end
        if (mem_we2) begin
            w2_addr.push_back(int'(mem_addr2));
            w2_data.push_back(int'(mem_wdata2));
        end
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        acc_cyc.delete(); done_cyc.delete();
        w2_addr.delete(); w2_data.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0;
        idle(2);
        check("rst_busy", busy, 0);
        check("rst_load", load, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_err", err_overflow, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        idle(2);

        // Streamed transfer of 3 words
        clear_log();
        do_start();
        check("t1_busy_after_start", busy, 1);
        check("t1_load_after_start", load, 1);
        check("t1_ready_after_start", in_ready, 1);
        send(16'd3);
        check("t1_ready_in_data", in_ready, 1);
        check("t1_err", err_overflow, 0);
        send(16'h000A);
        check("t1_we0", mem_we, 1);
        check("t1_addr0", mem_addr, 0);
        check("t1_data0", mem_wdata, 16'h000A);
        send(16'h0B0B);
        send(16'hFFFF);
        check("t1_last_we", mem_we, 1);
        check("t1_last_addr", mem_addr, 2);
        check("t1_last_data", mem_wdata, 16'hFFFF);
        check("t1_last_done", done, 1);
        check("t1_last_busy", busy, 0);
        check("t1_last_ready", in_ready, 0);
        step();
        check("t1_done_one_cycle", done, 0);
        idle(2);
        check("t1_nwrites", wr_addr.size(), 3);
        if (wr_addr.size() == 3) begin
            check("t1_a1", wr_addr[1], 1);
            check("t1_d1", wr_data[1], 16'h0B0B);
            check("t1_a2", wr_addr[2], 2);
            check("t1_consec01", wr_cyc[1] - wr_cyc[0], 1);
            check("t1_consec12", wr_cyc[2] - wr_cyc[1], 1);
            check("t1_done_with_last", done_cyc.size() == 1 && done_cyc[0] == wr_cyc[2], 1);
        end
        check("t1_busy_cycles", busy_cnt, 4);

        // Zero-length header
        clear_log();
        do_start();
        send(16'd0);
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        check("t2_we", mem_we, 0);
        check("t2_err", err_overflow, 0);
        step();
        check("t2_done_clear", done, 0);
        idle(2);
        check("t2_nwrites", wr_addr.size(), 0);
        check("t2_ndone", done_cnt, 1);

        // Header 4 with in_valid toggling; dut2 overflows
        clear_log();
        do_start();
        send(16'd4);
        check("t3_err_dut1", err_overflow, 0);
        check("t3_err_dut2", err_overflow2, 1);
        in_data = 16'hDEAD;
        step();
        send(16'h1111);
        in_data = 16'hDEAD;
        step();
        send(16'h2222);
        in_data = 16'hDEAD;
        step();
        send(16'h3333);
        in_data = 16'hDEAD;
        step();
        send(16'h4444);
        check("t3_done", done, 1);
        check("t3_done2", done2, 1);
        check("t3_last_data", mem_wdata, 16'h4444);
        idle(3);
        check("t3_nwrites", wr_addr.size(), 4);
        check("t3_naccepts", acc_cyc.size(), 5);
        if (wr_addr.size() == 4 && acc_cyc.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_addr%0d", i), wr_addr[i], i);
                check($sformatf("t3_lat%0d", i), wr_cyc[i] - acc_cyc[i+1], 1);
            end
            check("t3_data0", wr_data[0], 16'h1111);
            check("t3_data3", wr_data[3], 16'h4444);
        end
        check("t3_n2writes", w2_addr.size(), 2);
        if (w2_addr.size() == 2) begin
            check("t3_2addr0", w2_addr[0], 2);
            check("t3_2addr1", w2_addr[1], 3);
            check("t3_2data1", w2_data[1], 16'h2222);
        end
        check("t3_err2_sticky", err_overflow2, 1);

        // Reset mid-transfer
        clear_log();
        do_start();
        check("t4_err2_cleared", err_overflow2, 0);
        send(16'd5);
        send(16'h0101);
        send(16'h0202);
        check("t4_we_before_rst", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_we", mem_we, 0);
        check("t4_rst_addr", mem_addr, 0);
        check("t4_rst_wdata", mem_wdata, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_ready", in_ready, 0);
        check("t4_rst_err2", err_overflow2, 0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        step();
        check("t4_no_restart", busy, 0);
        in_valid = 1'b0;
        clear_log();
        do_start();
        send(16'd1);
        send(16'h5A5A);
        check("t4_new_we", mem_we, 1);
        check("t4_new_addr", mem_addr, 0);
        check("t4_new_data", mem_wdata, 16'h5A5A);
        check("t4_new_done", done, 1);

        // start during DATA and DONE is ignored
        idle(2);
        clear_log();
        do_start();
        send(16'd2);
        start = 1'b1;
        send(16'hAAAA);
        send(16'hBBBB);
        check("t5_done", done, 1);
        step();
        start = 1'b0;
        check("t5_busy_after_done", busy, 0);
        check("t5_ready_after_done", in_ready, 0);
        idle(2);
        check("t5_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("t5_addr1", wr_addr[1], 1);
            check("t5_data1", wr_data[1], 16'hBBBB);
        end
        check("t5_ndone", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1);
    end

endmodule
